// File: rtl/traffic_light_pkg.sv
// Shared phase encoding and lamp constants for the intersection phase scheduler.
package traffic_light_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5
  } phase_e;

  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;

  function automatic logic [2:0] main_lamp(input phase_e p);
    case (p)
      MAIN_GREEN:  main_lamp = LIGHT_G;
      MAIN_YELLOW: main_lamp = LIGHT_Y;
      default:     main_lamp = LIGHT_R;
    endcase
  endfunction

  function automatic logic [2:0] side_lamp(input phase_e p);
    case (p)
      SIDE_GREEN:  side_lamp = LIGHT_G;
      SIDE_YELLOW: side_lamp = LIGHT_Y;
      default:     side_lamp = LIGHT_R;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock into one-cycle timing ticks; frozen while enable is low.
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rstb,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_r;

  assign tick = enable && (count_r == LAST);

  // Free-running divider counter, wraps after the tick cycle
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      count_r <= '0;
    end else if (enable) begin
      if (count_r == LAST) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Timed green/yellow/all-red sequencer for a main/side intersection with
// on-demand side-road and pedestrian service after a guaranteed main green.
module traffic_phase_scheduler
  import traffic_light_pkg::*;
#(
  parameter int TICK_DIV     = 1000,
  parameter int T_MAIN_MIN   = 8,
  parameter int T_SIDE_GREEN = 5,
  parameter int T_YELLOW     = 2,
  parameter int T_ALL_RED    = 1,
  parameter int T_WALK       = 4,
  parameter int TW           = 8
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       enable,
  input  logic       side_car,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] phase
);

  localparam int T_SIDE_PED = (T_WALK > T_SIDE_GREEN) ? T_WALK : T_SIDE_GREEN;

  phase_e        state_r, state_s;
  logic [TW-1:0] timer_r, timer_s, timer_dec_s;
  logic [TW-1:0] walk_left_r, walk_left_s, walk_dec_s;
  logic          ped_pending_r, ped_pending_s, ped_set_s;
  logic          tick_s, expired_s, serve_s, walk_s;

  // Timer reload value (duration - 1) for the phase being entered
  function automatic logic [TW-1:0] load_value(input phase_e p, input logic ped);
    case (p)
      MAIN_GREEN:  load_value = TW'(T_MAIN_MIN - 1);
      MAIN_YELLOW: load_value = TW'(T_YELLOW - 1);
      ALL_RED_A:   load_value = TW'(T_ALL_RED - 1);
      SIDE_GREEN:  load_value = ped ? TW'(T_SIDE_PED - 1) : TW'(T_SIDE_GREEN - 1);
      SIDE_YELLOW: load_value = TW'(T_YELLOW - 1);
      ALL_RED_B:   load_value = TW'(T_ALL_RED - 1);
      default:     load_value = TW'(T_MAIN_MIN - 1);
    endcase
  endfunction

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .rstb   (rstb),
    .enable (enable),
    .tick   (tick_s)
  );

  // Next-state, timer, walk window and pedestrian latch
  always_comb begin
    state_s     = state_r;
    ped_set_s   = ped_pending_r | ped_req;
    serve_s     = ped_pending_r | ped_req;
    expired_s   = tick_s && (timer_r == '0);
    timer_dec_s = timer_r;
    walk_dec_s  = walk_left_r;

    if (tick_s && (timer_r != '0)) begin
      timer_dec_s = timer_r - TW'(1);
    end else begin
      timer_dec_s = timer_r;
    end

    if (tick_s && (walk_left_r != '0)) begin
      walk_dec_s = walk_left_r - TW'(1);
    end else begin
      walk_dec_s = walk_left_r;
    end

    if (expired_s) begin
      case (state_r)
        MAIN_GREEN: begin
          // A waiting main green keeps its timer at zero until demand shows up
          if (side_car || ped_pending_r) begin
            state_s = MAIN_YELLOW;
          end else begin
            state_s = MAIN_GREEN;
          end
        end
        MAIN_YELLOW: state_s = ALL_RED_A;
        ALL_RED_A:   state_s = SIDE_GREEN;
        SIDE_GREEN:  state_s = SIDE_YELLOW;
        SIDE_YELLOW: state_s = ALL_RED_B;
        ALL_RED_B:   state_s = MAIN_GREEN;
        default:     state_s = MAIN_GREEN;
      endcase
    end else begin
      state_s = state_r;
    end

    if (state_s != state_r) begin
      timer_s = load_value(state_s, serve_s);
      if (state_s == SIDE_GREEN) begin
        // Entering side green serves any request, including one arriving now
        ped_pending_s = 1'b0;
        walk_left_s   = serve_s ? TW'(T_WALK) : '0;
      end else begin
        ped_pending_s = ped_set_s;
        walk_left_s   = '0;
      end
    end else begin
      timer_s       = timer_dec_s;
      walk_left_s   = walk_dec_s;
      ped_pending_s = ped_set_s;
    end

    walk_s = (state_s == SIDE_GREEN) && (walk_left_s != '0);
  end

  // State, timer and registered lamp/walk outputs
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r       <= MAIN_GREEN;
      timer_r       <= TW'(T_MAIN_MIN - 1);
      walk_left_r   <= '0;
      ped_pending_r <= 1'b0;
      main_light    <= LIGHT_G;
      side_light    <= LIGHT_R;
      walk          <= 1'b0;
    end else begin
      state_r       <= state_s;
      timer_r       <= timer_s;
      walk_left_r   <= walk_left_s;
      ped_pending_r <= ped_pending_s;
      main_light    <= main_lamp(state_s);
      side_light    <= side_lamp(state_s);
      walk          <= walk_s;
    end
  end

  assign phase = state_r;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: three parameterisations run side by side
// against a phase/elapsed-tick reference model plus directed timing points.
module tb_traffic_phase_scheduler;

  typedef struct {
    int div;
    int tmin;
    int tsg;
    int ty;
    int tar;
    int tw;
  } cfg_t;

  typedef struct {
    int ph;
    int el;
    int pc;
    bit pend;
    bit served;
  } mst_t;

  logic clk  = 1'b0;
  logic rstb = 1'b1;
  logic [2:0]      en;
  logic [2:0]      car;
  logic [2:0]      ped;
  logic [2:0]      wk;
  logic [2:0][2:0] ml;
  logic [2:0][2:0] sl;
  logic [2:0][2:0] ph;

  cfg_t cfg[3];
  mst_t st[3];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  int   ph_hist[3][200];
  logic wk_hist[3][200];
  int   walk_count;

  always #5 clk = ~clk;

  traffic_phase_scheduler #(.TICK_DIV(1)) dut0 (
    .clk(clk), .rstb(rstb), .enable(en[0]), .side_car(car[0]), .ped_req(ped[0]),
    .main_light(ml[0]), .side_light(sl[0]), .walk(wk[0]), .phase(ph[0]));

  traffic_phase_scheduler #(.TICK_DIV(1), .T_WALK(7)) dut1 (
    .clk(clk), .rstb(rstb), .enable(en[1]), .side_car(car[1]), .ped_req(ped[1]),
    .main_light(ml[1]), .side_light(sl[1]), .walk(wk[1]), .phase(ph[1]));

  traffic_phase_scheduler #(.TICK_DIV(4)) dut2 (
    .clk(clk), .rstb(rstb), .enable(en[2]), .side_car(car[2]), .ped_req(ped[2]),
    .main_light(ml[2]), .side_light(sl[2]), .walk(wk[2]), .phase(ph[2]));

  function automatic int dur(cfg_t c, int p, bit served);
    case (p)
      0:       return c.tmin;
      1, 4:    return c.ty;
      2, 5:    return c.tar;
      3:       return (served && c.tw > c.tsg) ? c.tw : c.tsg;
      default: return c.tmin;
    endcase
  endfunction

  function automatic mst_t model_step(cfg_t c, mst_t s, logic e, logic car_i, logic ped_i);
    mst_t n;
    bit   tick;
    n    = s;
    tick = e && (s.pc == c.div - 1);
    if (e) n.pc = tick ? 0 : s.pc + 1;
    n.pend = s.pend || ped_i;
    if (tick) begin
      if (s.el + 1 < dur(c, s.ph, s.served)) begin
        n.el = s.el + 1;
      end else if (s.ph == 0 && !(car_i || s.pend)) begin
        n.el = s.el;
      end else begin
        n.ph = (s.ph + 1) % 6;
        n.el = 0;
        if (n.ph == 3) begin
          n.served = s.pend || ped_i;
          n.pend   = 1'b0;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [2:0] exp_main(int p);
    return (p == 0) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] exp_side(int p);
    return (p == 3) ? 3'b001 : (p == 4) ? 3'b010 : 3'b100;
  endfunction

  function automatic int plan_phase(int c);
    if (c <= 7)  return 0;
    if (c <= 9)  return 1;
    if (c == 10) return 2;
    if (c <= 15) return 3;
    if (c <= 17) return 4;
    if (c == 18) return 5;
    return 0;
  endfunction

  task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s dut%0d t=%0t observed=%0h expected=%0h", tag, i, $time, obs, exp);
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("phase", i, 32'(ph[i]), 32'(st[i].ph));
      chk("main_light", i, 32'(ml[i]), 32'(exp_main(st[i].ph)));
      chk("side_light", i, 32'(sl[i]), 32'(exp_side(st[i].ph)));
      chk("walk", i, 32'(wk[i]),
          32'(st[i].ph == 3 && st[i].served && st[i].el < cfg[i].tw));
      chk("no_conflict", i, 32'(ml[i] == 3'b100 || sl[i] == 3'b100), 32'd1);
      chk("walk_main_red", i, 32'(!wk[i] || ml[i] == 3'b100), 32'd1);
      chk("main_onehot", i, 32'($onehot(ml[i])), 32'd1);
      chk("side_onehot", i, 32'($onehot(sl[i])), 32'd1);
    end
  endtask

  task automatic record();
    if (cyc < 200) begin
      for (int i = 0; i < 3; i++) begin
        ph_hist[i][cyc] = int'(ph[i]);
        wk_hist[i][cyc] = wk[i];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) st[i] = model_step(cfg[i], st[i], en[i], car[i], ped[i]);
    #1;
    check_all();
    cyc = cyc + 1;
    record();
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) st[i] = '{ph: 0, el: 0, pc: 0, pend: 1'b0, served: 1'b0};
    check_all();
    @(posedge clk);
    #1;
    rstb = 1'b1;
    cyc  = 0;
    record();
  endtask

  task automatic idle_inputs();
    en  = 3'b111;
    car = 3'b000;
    ped = 3'b000;
  endtask

  initial begin
    cfg[0] = '{div: 1, tmin: 8, tsg: 5, ty: 2, tar: 1, tw: 4};
    cfg[1] = '{div: 1, tmin: 8, tsg: 5, ty: 2, tar: 1, tw: 7};
    cfg[2] = '{div: 4, tmin: 8, tsg: 5, ty: 2, tar: 1, tw: 4};
    idle_inputs();
    #1;
    do_reset();

    // Directed timing: side car on dut0/dut2, ped pulse on dut1, freeze on dut2
    for (int k = 0; k < 50; k++) begin
      car[0] = 1'b1;
      car[1] = 1'b0;
      ped[1] = (k == 3);
      car[2] = 1'b1;
      en[2]  = !(k >= 20 && k < 30);
      step();
    end
    for (int c = 0; c < 20; c++) chk("plan_seq", 0, 32'(ph_hist[0][c]), 32'(plan_phase(c)));
    chk("ped_mg_hold", 1, 32'(ph_hist[1][7]), 32'd0);
    chk("ped_my_entry", 1, 32'(ph_hist[1][8]), 32'd1);
    for (int c = 11; c <= 17; c++) begin
      chk("ped_sg_len", 1, 32'(ph_hist[1][c]), 32'd3);
      chk("ped_walk_on", 1, 32'(wk_hist[1][c]), 32'd1);
    end
    chk("ped_sy_entry", 1, 32'(ph_hist[1][18]), 32'd4);
    chk("ped_walk_off", 1, 32'(wk_hist[1][18]), 32'd0);
    chk("ped_cleared", 1, 32'(ph_hist[1][49]), 32'd0);
    chk("freeze_mg", 2, 32'(ph_hist[2][41]), 32'd0);
    chk("freeze_my", 2, 32'(ph_hist[2][42]), 32'd1);

    // No requests: main green holds indefinitely
    do_reset();
    idle_inputs();
    for (int k = 0; k < 100; k++) begin
      step();
      chk("idle_phase", 0, 32'(ph[0]), 32'd0);
      chk("idle_main", 2, 32'(ml[2]), 32'b001);
    end

    // ped_req coinciding with side-green entry while already pending
    do_reset();
    idle_inputs();
    walk_count = 0;
    for (int k = 0; k < 40; k++) begin
      car[0] = (k < 12);
      ped[0] = (k == 2 || k == 10);
      step();
      if (wk[0]) walk_count = walk_count + 1;
    end
    chk("sim_walk_start", 0, 32'(wk_hist[0][11]), 32'd1);
    chk("sim_walk_end", 0, 32'(wk_hist[0][15]), 32'd0);
    chk("sim_walk_once", 0, 32'(walk_count), 32'd4);
    chk("sim_pend_clear", 0, 32'(ph_hist[0][39]), 32'd0);

    // Asynchronous reset in the middle of side green with walk active
    do_reset();
    idle_inputs();
    for (int k = 0; k < 13; k++) begin
      car[0] = 1'b1;
      ped[0] = (k == 2);
      step();
    end
    chk("pre_rst_sg", 0, 32'(ph[0]), 32'd3);
    chk("pre_rst_walk", 0, 32'(wk[0]), 32'd1);
    #1;
    do_reset();

    // Randomised traffic
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < 3; i++) begin
        en[i]  = ($urandom_range(0, 9) != 0);
        car[i] = ($urandom_range(0, 3) == 0);
        ped[i] = ($urandom_range(0, 15) == 0);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
